// File: rtl/vga_scan_gen.sv
// VGA scan counters, registered sync/visible/pixel decode and a triangle vertex bank.
// Define SCAN_VERT_BUF_EN to double-buffer the vertex bank with commit at frame start.
module vga_scan_gen #(
  parameter int unsigned H_TOTAL     = 1586,
  parameter int unsigned H_SYNC      = 190,
  parameter int unsigned H_VIS_START = 285,
  parameter int unsigned H_VIS_END   = 1555,
  parameter int unsigned V_TOTAL     = 526,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 515,
  parameter int unsigned PIX_SHIFT   = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        vert_wr,
  input  logic [2:0]  vert_sel,
  input  logic [11:0] vert_data,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        visible,
  output logic [11:0] px,
  output logic [11:0] py,
  output logic        frame_start,
  output logic        line_start,
  output logic [11:0] x1,
  output logic [11:0] y1,
  output logic [11:0] x2,
  output logic [11:0] y2,
  output logic [11:0] x3,
  output logic [11:0] y3,
  output logic        vert_pending
);

  localparam int unsigned CW = 12;
  localparam int unsigned XW = $clog2(H_TOTAL);
  localparam int unsigned YW = $clog2(V_TOTAL);
  localparam int unsigned NV = 6;

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          cx_last;
  logic          cy_last;
  logic          at_origin;

  assign cx_last   = (cx == XW'(H_TOTAL - 1));
  assign cy_last   = (cy == YW'(V_TOTAL - 1));
  assign at_origin = (cx == '0) && (cy == '0);

  // Scan position counters
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (cx_last) begin
      cx <= '0;
      cy <= cy_last ? '0 : cy + YW'(1);
    end else begin
      cx <= cx + XW'(1);
    end
  end

  logic          h_vis_c;
  logic          v_vis_c;
  logic          vis_c;
  logic [XW-1:0] dx_c;
  logic [YW-1:0] dy_c;
  logic [CW-1:0] px_c;
  logic [CW-1:0] py_c;

  always_comb begin
    h_vis_c = (cx >= XW'(H_VIS_START)) && (cx < XW'(H_VIS_END));
    v_vis_c = (cy >= YW'(V_VIS_START)) && (cy < YW'(V_VIS_END));
    vis_c   = h_vis_c && v_vis_c;
    dx_c    = cx - XW'(H_VIS_START);
    dy_c    = cy - YW'(V_VIS_START);
    px_c    = '0;
    py_c    = '0;
    if (vis_c) begin
      px_c = CW'(dx_c >> PIX_SHIFT);
      py_c = CW'(dy_c);
    end
  end

  // Decoded outputs, one cycle behind the counters and aligned with each other
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      VGA_HS      <= 1'b0;
      VGA_VS      <= 1'b0;
      visible     <= 1'b0;
      px          <= '0;
      py          <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      VGA_HS      <= (cx >= XW'(H_SYNC));
      VGA_VS      <= (cy >= YW'(V_SYNC));
      visible     <= vis_c;
      px          <= px_c;
      py          <= py_c;
      frame_start <= at_origin;
      line_start  <= (cx == '0);
    end
  end

  logic [CW-1:0] active [NV];
  logic          wr_hit;

  assign wr_hit = vert_wr && (vert_sel < 3'(NV));

`ifdef SCAN_VERT_BUF_EN
  logic [CW-1:0] shadow [NV];

  // Commit reads the pre-write shadow, so a write on the commit edge waits a frame
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned i = 0; i < NV; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      vert_pending <= 1'b0;
    end else begin
      if (at_origin) begin
        active       <= shadow;
        vert_pending <= 1'b0;
      end
      if (wr_hit) begin
        vert_pending <= 1'b1;
      end
      for (int unsigned i = 0; i < NV; i++) begin
        if (wr_hit && (vert_sel == 3'(i))) begin
          shadow[i] <= vert_data;
        end
      end
    end
  end
`else
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned i = 0; i < NV; i++) begin
        active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NV; i++) begin
        if (wr_hit && (vert_sel == 3'(i))) begin
          active[i] <= vert_data;
        end
      end
    end
  end

  assign vert_pending = 1'b0;
`endif

  assign x1 = active[0];
  assign y1 = active[1];
  assign x2 = active[2];
  assign y2 = active[3];
  assign x3 = active[4];
  assign y3 = active[5];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: a full-geometry instance checks reset and line timing,
// a reduced-geometry instance checks visible window edges and the vertex bank over several frames.
module tb_vga_scan_gen;

  localparam int S_HS = 0, S_VS = 1, S_VIS = 2, S_PX = 3, S_PY = 4, S_FS = 5, S_LS = 6;
  localparam int S_X1 = 7, S_Y1 = 8, S_X2 = 9, S_Y2 = 10, S_X3 = 11, S_Y3 = 12, S_PEND = 13;
  localparam int BIG = 0, SML = 1;

  logic        CLOCK_50;
  logic        reset;
  logic        vert_wr;
  logic [2:0]  vert_sel;
  logic [11:0] vert_data;

  logic        hs_b, vs_b, vis_b, fs_b, ls_b, pend_b;
  logic [11:0] px_b, py_b, x1_b, y1_b, x2_b, y2_b, x3_b, y3_b;
  logic        hs_s, vs_s, vis_s, fs_s, ls_s, pend_s;
  logic [11:0] px_s, py_s, x1_s, y1_s, x2_s, y2_s, x3_s, y3_s;

  vga_scan_gen dut_big (
    .CLOCK_50(CLOCK_50), .reset(reset), .vert_wr(vert_wr), .vert_sel(vert_sel),
    .vert_data(vert_data), .VGA_HS(hs_b), .VGA_VS(vs_b), .visible(vis_b), .px(px_b),
    .py(py_b), .frame_start(fs_b), .line_start(ls_b), .x1(x1_b), .y1(y1_b), .x2(x2_b),
    .y2(y2_b), .x3(x3_b), .y3(y3_b), .vert_pending(pend_b)
  );

  // 40 clocks x 12 lines = 480-clock frame
  vga_scan_gen #(
    .H_TOTAL(40), .H_SYNC(6), .H_VIS_START(10), .H_VIS_END(36),
    .V_TOTAL(12), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(10), .PIX_SHIFT(1)
  ) dut_sml (
    .CLOCK_50(CLOCK_50), .reset(reset), .vert_wr(vert_wr), .vert_sel(vert_sel),
    .vert_data(vert_data), .VGA_HS(hs_s), .VGA_VS(vs_s), .visible(vis_s), .px(px_s),
    .py(py_s), .frame_start(fs_s), .line_start(ls_s), .x1(x1_s), .y1(y1_s), .x2(x2_s),
    .y2(y2_s), .x3(x3_s), .y3(y3_s), .vert_pending(pend_s)
  );

  typedef struct {
    int cyc;
    int dut;
    int sig;
    int val;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic string sig_name(int s);
    case (s)
      S_HS: return "VGA_HS";   S_VS: return "VGA_VS";  S_VIS: return "visible";
      S_PX: return "px";       S_PY: return "py";      S_FS: return "frame_start";
      S_LS: return "line_start"; S_X1: return "x1";    S_Y1: return "y1";
      S_X2: return "x2";       S_Y2: return "y2";      S_X3: return "x3";
      S_Y3: return "y3";       default: return "vert_pending";
    endcase
  endfunction

  function automatic int get_sig(int d, int s);
    logic [11:0] v;
    v = '0;
    case (s)
      S_HS:    v = (d == BIG) ? 12'(hs_b)   : 12'(hs_s);
      S_VS:    v = (d == BIG) ? 12'(vs_b)   : 12'(vs_s);
      S_VIS:   v = (d == BIG) ? 12'(vis_b)  : 12'(vis_s);
      S_PX:    v = (d == BIG) ? px_b        : px_s;
      S_PY:    v = (d == BIG) ? py_b        : py_s;
      S_FS:    v = (d == BIG) ? 12'(fs_b)   : 12'(fs_s);
      S_LS:    v = (d == BIG) ? 12'(ls_b)   : 12'(ls_s);
      S_X1:    v = (d == BIG) ? x1_b        : x1_s;
      S_Y1:    v = (d == BIG) ? y1_b        : y1_s;
      S_X2:    v = (d == BIG) ? x2_b        : x2_s;
      S_Y2:    v = (d == BIG) ? y2_b        : y2_s;
      S_X3:    v = (d == BIG) ? x3_b        : x3_s;
      S_Y3:    v = (d == BIG) ? y3_b        : y3_s;
      default: v = (d == BIG) ? 12'(pend_b) : 12'(pend_s);
    endcase
    return int'(v);
  endfunction

  // Keep the queue ordered by cycle so the monitor only ever looks at the head
  task automatic expect_at(int c, int d, int s, int v);
    exp_t e;
    int   idx;
    e.cyc = c; e.dut = d; e.sig = s; e.val = v;
    idx = q.size();
    while (idx > 0 && q[idx-1].cyc > c) idx--;
    q.insert(idx, e);
  endtask

  always @(negedge CLOCK_50) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int   got;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL missed_%s dut%0d cyc %0d", sig_name(e.sig), e.dut, e.cyc);
      end else begin
        got = get_sig(e.dut, e.sig);
        if (got != e.val) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d got %0d want %0d", sig_name(e.sig), e.dut, cyc, got, e.val);
        end
      end
    end
  end

  task automatic at_cycle(int c);
    while (cyc < c - 1) @(negedge CLOCK_50);
  endtask

  task automatic wr(int c, logic [2:0] sel, logic [11:0] data);
    at_cycle(c);
    vert_wr = 1'b1; vert_sel = sel; vert_data = data;
    at_cycle(c + 1);
    vert_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vert_wr = 1'b0; vert_sel = '0; vert_data = '0;

    // Reset held for cycles 1..3, first decode of (0,0) shows at cycle 4
    for (int c = 1; c <= 3; c++) begin
      for (int d = BIG; d <= SML; d++) begin
        expect_at(c, d, S_FS, 0);  expect_at(c, d, S_LS, 0);
        expect_at(c, d, S_HS, 0);  expect_at(c, d, S_VS, 0);
        expect_at(c, d, S_VIS, 0); expect_at(c, d, S_PEND, 0);
      end
    end
    for (int d = BIG; d <= SML; d++) begin
      expect_at(4, d, S_FS, 1); expect_at(4, d, S_LS, 1);
      expect_at(4, d, S_HS, 0); expect_at(4, d, S_VS, 0);
      expect_at(5, d, S_FS, 0); expect_at(5, d, S_LS, 0);
    end

    // Full geometry: line period and sync edges
    expect_at(193, BIG, S_HS, 0);   expect_at(194, BIG, S_HS, 1);
    expect_at(1589, BIG, S_LS, 0);  expect_at(1590, BIG, S_LS, 1);
    expect_at(1590, BIG, S_HS, 0);  expect_at(1590, BIG, S_VS, 0);
    expect_at(1591, BIG, S_LS, 0);  expect_at(1590, BIG, S_FS, 0);
    expect_at(3175, BIG, S_VS, 0);  expect_at(3176, BIG, S_VS, 1);

    // Reduced geometry: sync, line start, visible window edges
    expect_at(9, SML, S_HS, 0);     expect_at(10, SML, S_HS, 1);
    expect_at(43, SML, S_LS, 0);    expect_at(44, SML, S_LS, 1);
    expect_at(133, SML, S_VIS, 0);
    expect_at(134, SML, S_VIS, 1);  expect_at(134, SML, S_PX, 0); expect_at(134, SML, S_PY, 0);
    expect_at(135, SML, S_PX, 0);   expect_at(136, SML, S_PX, 1);
    expect_at(159, SML, S_VIS, 1);  expect_at(159, SML, S_PX, 12);
    expect_at(160, SML, S_VIS, 0);  expect_at(160, SML, S_PX, 0); expect_at(160, SML, S_PY, 0);
    expect_at(174, SML, S_VIS, 1);  expect_at(174, SML, S_PX, 0); expect_at(174, SML, S_PY, 1);
    expect_at(384, SML, S_VIS, 1);  expect_at(384, SML, S_PX, 5); expect_at(384, SML, S_PY, 6);
    for (int c = 404; c <= 443; c++) expect_at(c, SML, S_VIS, 0);
    expect_at(483, SML, S_FS, 0);   expect_at(484, SML, S_FS, 1);
    expect_at(964, SML, S_FS, 1);

`ifdef SCAN_VERT_BUF_EN
    expect_at(151, SML, S_X1, 0);   expect_at(151, SML, S_PEND, 0);
    expect_at(200, SML, S_PEND, 1); expect_at(200, SML, S_X3, 0);
    expect_at(300, SML, S_X3, 0);   expect_at(300, SML, S_Y3, 0);
    expect_at(300, SML, S_X2, 0);   expect_at(300, SML, S_PEND, 1);
    expect_at(483, SML, S_X3, 0);   expect_at(483, SML, S_Y3, 0); expect_at(483, SML, S_PEND, 1);
    expect_at(484, SML, S_X3, 25);  expect_at(484, SML, S_Y3, 4092);
    expect_at(484, SML, S_X2, 20);  expect_at(484, SML, S_PEND, 0);
    expect_at(600, SML, S_PEND, 1); expect_at(600, SML, S_Y1, 0);
    expect_at(963, SML, S_Y1, 0);
    expect_at(964, SML, S_Y1, 3);   expect_at(964, SML, S_PEND, 1);
    expect_at(1443, SML, S_Y1, 3);  expect_at(1443, SML, S_PEND, 1);
    expect_at(1444, SML, S_Y1, 7);  expect_at(1444, SML, S_PEND, 0); expect_at(1444, SML, S_X3, 25);
`else
    expect_at(151, SML, S_X1, 0);   expect_at(151, SML, S_X2, 0); expect_at(151, SML, S_PEND, 0);
    expect_at(199, SML, S_X3, 0);   expect_at(200, SML, S_X3, 25);
    expect_at(201, SML, S_Y3, 4092);
    expect_at(209, SML, S_X2, 0);   expect_at(210, SML, S_X2, 20); expect_at(210, SML, S_PEND, 0);
    expect_at(484, SML, S_X2, 20);  expect_at(484, SML, S_PEND, 0);
    expect_at(600, SML, S_Y1, 3);
    expect_at(963, SML, S_Y1, 3);   expect_at(964, SML, S_Y1, 7); expect_at(964, SML, S_PEND, 0);
`endif

    // Mid-frame reset with a concurrent write: everything clears, write is dropped
    expect_at(3300, SML, S_Y1, 0);  expect_at(3300, SML, S_X3, 0);
    expect_at(3300, SML, S_X2, 0);  expect_at(3300, SML, S_PEND, 0);
    expect_at(3300, SML, S_VIS, 0); expect_at(3300, SML, S_PX, 0);
    expect_at(3301, SML, S_FS, 0);  expect_at(3301, SML, S_X1, 0);
    expect_at(3302, SML, S_FS, 1);  expect_at(3302, SML, S_LS, 1);
    expect_at(3302, SML, S_X1, 0);  expect_at(3302, SML, S_PEND, 0);
    expect_at(3302, BIG, S_FS, 1);

    at_cycle(4);
    reset = 1'b0;
    wr(150, 3'd6, 12'd99);
    wr(200, 3'd4, 12'd25);
    wr(201, 3'd5, 12'hFFC);
    wr(210, 3'd2, 12'd20);
    wr(600, 3'd1, 12'd3);
    wr(964, 3'd1, 12'd7);

    at_cycle(3300);
    reset = 1'b1; vert_wr = 1'b1; vert_sel = 3'd0; vert_data = 12'd55;
    at_cycle(3302);
    reset = 1'b0; vert_wr = 1'b0;

    at_cycle(3310);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge CLOCK_50);
    if (q.size() > 0) begin
      errors += q.size();
      $display("FAIL unchecked_expectations left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
